// File: rtl/drum_div_if.sv
// Operand/result handshake bundle for the DRUM approximate divider.
// The master drives operands and consumes results; the slave is the divider.
interface drum_div_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic             dz;
    logic             ovf;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, q, dz, ovf
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, q, dz, ovf
    );
endinterface

// File: rtl/drum_div_seq.sv
// Iterative approximate divider, the inverse of the DRUM multiplier.
// The divisor is truncated to K bits from its leading one with the LSB
// forced to 1. The dividend is pre-shifted by the same amount. A one-bit
// per cycle restoring division then runs on the reduced operands.
module drum_div_seq #(
    parameter int WIDTH = 16,
    parameter int K     = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    drum_div_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, DIV, FIX, DONE} state_t;

    // Control state, reset to a known idle condition.
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovld_q, ovld_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    // Datapath registers; their contents only matter once loaded.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic             sq_q, sq_d;
    logic             aneg_q, aneg_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [K:0]       rem_q, rem_d;
    logic [K-1:0]     bt_q, bt_d;

    logic             in_ready;
    logic             accept;

    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    int               kb;
    int               sb;
    logic [WIDTH-1:0] dvd_init;
    logic [K-1:0]     bt_init;
    logic [K+1:0]     t;
    logic [K+1:0]     bt_ext;
    logic [WIDTH:0]   fix_res;

    // Final quotient forming: divide-by-zero saturation, sign restore and
    // positive overflow saturation. Returns {ovf, q}.
    function automatic logic [WIDTH:0] fix_result(
        input logic             dz,
        input logic             sgn,
        input logic             sq,
        input logic             aneg,
        input logic [WIDTH-1:0] mag
    );
        logic signed [WIDTH-1:0] mag_s;
        logic        [WIDTH-1:0] neg;
        logic        [WIDTH-1:0] pos_max;
        logic        [WIDTH-1:0] neg_min;
        pos_max = {1'b0, {(WIDTH-1){1'b1}}};
        neg_min = {1'b1, {(WIDTH-1){1'b0}}};
        mag_s   = $signed(mag);
        neg     = -mag_s;
        if (dz) begin
            if (sgn)
                return {1'b0, (aneg ? neg_min : pos_max)};
            return {1'b0, {WIDTH{1'b1}}};
        end
        if (sgn && sq)
            return {1'b0, neg};
        if (sgn && mag[WIDTH-1])
            return {1'b1, pos_max};
        return {1'b0, mag};
    endfunction

    // Operand preparation: magnitudes, leading-one search and truncation.
    always_comb begin
        ma = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        mb = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
        kb = 0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mb[i]) kb = i;
        end
        if (kb >= K) begin
            sb      = kb - K + 1;
            bt_init = K'(mb >> sb) | K'(1);
        end else begin
            sb      = 0;
            bt_init = K'(mb);
        end
        dvd_init = ma >> sb;
    end

    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign accept   = bus.in_valid && in_ready;
    assign t        = {rem_q, dvd_q[WIDTH-1]};
    assign bt_ext   = {2'b00, bt_q};
    assign fix_res  = fix_result(dz_q, sgn_q, sq_q, aneg_q, dvd_q);

    // Next-state and datapath update for every FSM state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovld_d  = ovld_q;
        q_d     = q_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        sq_d    = sq_q;
        aneg_d  = aneg_q;
        dvd_d   = dvd_q;
        rem_d   = rem_q;
        bt_d    = bt_q;

        if (accept) begin
            a_d     = bus.a;
            b_d     = bus.b;
            sgn_d   = bus.is_signed;
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
            ovld_d  = 1'b0;
            state_d = PREP;
        end else begin
            case (state_q)
                IDLE: ;
                PREP: begin
                    sq_d   = sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                    aneg_d = sgn_q && a_q[WIDTH-1];
                    dvd_d  = dvd_init;
                    bt_d   = bt_init;
                    rem_d  = '0;
                    cnt_d  = CW'(WIDTH - 1);
                    if (mb == '0) begin
                        dz_d    = 1'b1;
                        state_d = FIX;
                    end else begin
                        state_d = DIV;
                    end
                end
                DIV: begin
                    if (t >= bt_ext) begin
                        rem_d = (K+1)'(t - bt_ext);
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = t[K:0];
                        dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == '0) state_d = FIX;
                end
                FIX: begin
                    ovf_d   = fix_res[WIDTH];
                    q_d     = fix_res[WIDTH-1:0];
                    ovld_d  = 1'b1;
                    state_d = DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        ovld_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM and result registers; reset aborts any division in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovld_q  <= 1'b0;
            q_q     <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovld_q  <= ovld_d;
            q_q     <= q_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Operand and division working registers.
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        sgn_q  <= sgn_d;
        sq_q   <= sq_d;
        aneg_q <= aneg_d;
        dvd_q  <= dvd_d;
        rem_q  <= rem_d;
        bt_q   <= bt_d;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = ovld_q;
    assign bus.q         = q_q;
    assign bus.dz        = dz_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_drum_div_seq.sv
// Self-checking bench for drum_div_seq: expected results are queued when
// operands are accepted and compared when the divider presents a result.
module tb_drum_div_seq;
    localparam int WIDTH = 16;
    localparam int K     = 6;

    typedef struct packed {
        logic [15:0] q;
        logic        dz;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    drum_div_if #(.WIDTH(WIDTH)) bus ();
    drum_div_seq #(.WIDTH(WIDTH), .K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    res_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Arithmetic reference: truncated divisor, shifted dividend, integer divide.
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic sgn);
        res_t r;
        int ia, ib, ma, mb, kb, sb, bt, qm;
        ia = a; ib = b;
        ma = (sgn && a[15]) ? 65536 - ia : ia;
        mb = (sgn && b[15]) ? 65536 - ib : ib;
        r.dz = 1'b0; r.ovf = 1'b0;
        if (mb == 0) begin
            r.dz = 1'b1;
            r.q  = sgn ? (a[15] ? 16'h8000 : 16'h7fff) : 16'hffff;
            return r;
        end
        kb = 0;
        for (int i = 0; i < 17; i++) if (((mb >> i) & 1) == 1) kb = i;
        if (kb >= K) begin
            sb = kb - K + 1;
            bt = (mb >> sb) | 1;
            qm = (ma >> sb) / bt;
        end else begin
            qm = ma / mb;
        end
        if (sgn && (a[15] ^ b[15])) r.q = 16'(-qm);
        else if (sgn && qm > 32767) begin r.q = 16'h7fff; r.ovf = 1'b1; end
        else r.q = 16'(qm);
        return r;
    endfunction

    // Present operands, wait (bounded) for acceptance, queue the expectation.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sgn, input res_t exp);
        int waited;
        @(negedge clk);
        bus.a = a; bus.b = b; bus.is_signed = sgn; bus.in_valid = 1'b1;
        waited = 0;
        while (!bus.in_ready && waited < 100) begin
            @(posedge clk); @(negedge clk); waited++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        sb_q.push_back(exp);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Count edges from the accept edge until out_valid, then score the result.
    task automatic wait_out(input int exp_lat, input string tag);
        int   lat;
        res_t e;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); lat++; @(negedge clk);
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_q"}, 32'(bus.q), 32'(e.q));
            check({tag, "_dz"}, 32'(bus.dz), 32'(e.dz));
            check({tag, "_ovf"}, 32'(bus.ovf), 32'(e.ovf));
        end
    endtask

    task automatic release_out(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_idle_rdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic sgn,
                       input res_t exp, input int lat, input string tag);
        send(a, b, sgn, exp);
        wait_out(lat, tag);
        release_out(tag);
    endtask

    initial begin
        res_t r;
        logic [15:0] ra, rb;
        logic        rs;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.is_signed = 1'b0; bus.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q", 32'(bus.q), 32'd0);
        check("rst_dz", 32'(bus.dz), 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;

        run(16'd1000, 16'd7, 1'b0, '{q: 16'd142, dz: 1'b0, ovf: 1'b0}, 18, "u1000_7");
        run(16'd60000, 16'd1000, 1'b0, '{q: 16'd59, dz: 1'b0, ovf: 1'b0}, 18, "u60000_1000");
        run(16'hff9c, 16'd7, 1'b1, '{q: 16'hfff2, dz: 1'b0, ovf: 1'b0}, 18, "s_m100_7");
        run(16'h8000, 16'hffff, 1'b1, '{q: 16'h7fff, dz: 1'b0, ovf: 1'b1}, 18, "s_ovf");
        run(16'd5, 16'd0, 1'b0, '{q: 16'hffff, dz: 1'b1, ovf: 1'b0}, 2, "u_dz");
        run(16'hfffb, 16'd0, 1'b1, '{q: 16'h8000, dz: 1'b1, ovf: 1'b0}, 2, "s_dz_neg");
        run(16'd5, 16'd0, 1'b1, '{q: 16'h7fff, dz: 1'b1, ovf: 1'b0}, 2, "s_dz_pos");
        run(16'h8000, 16'd1, 1'b1, '{q: 16'h8000, dz: 1'b0, ovf: 1'b0}, 18, "s_min_1");

        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = (i % 2 == 1) ? 16'($urandom_range(1, 63)) : 16'($urandom_range(0, 65535));
            rs = (i >= 4);
            r  = model(ra, rb, rs);
            run(ra, rb, rs, r, r.dz ? 2 : 18, $sformatf("rnd%0d", i));
        end

        // Backpressure, then a back-to-back accept in DONE.
        send(16'd1000, 16'd7, 1'b0, '{q: 16'd142, dz: 1'b0, ovf: 1'b0});
        wait_out(18, "bp_first");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("bp_hold_q%0d", i), 32'(bus.q), 32'd142);
            check($sformatf("bp_hold_vld%0d", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp_hold_rdy%0d", i), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.a = 16'd1000; bus.b = 16'd7; bus.is_signed = 1'b0;
        #1;
        check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        sb_q.push_back('{q: 16'd142, dz: 1'b0, ovf: 1'b0});
        @(negedge clk);
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check("b2b_vld_drop", 32'(bus.out_valid), 32'd0);
        check("b2b_busy", 32'(bus.in_ready), 32'd0);
        wait_out(18, "b2b_second");
        release_out("b2b_second");

        // Reset in the middle of the division.
        send(16'd60000, 16'd1000, 1'b0, '{q: 16'd59, dz: 1'b0, ovf: 1'b0});
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check("mid_rst_vld", 32'(bus.out_valid), 32'd0);
        check("mid_rst_q", 32'(bus.q), 32'd0);
        check("mid_rst_rdy", 32'(bus.in_ready), 32'd1);
        sb_q.delete();
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        @(negedge clk);
        check("mid_rst_stays_idle", 32'(bus.out_valid), 32'd0);
        run(16'd60000, 16'd1000, 1'b0, '{q: 16'd59, dz: 1'b0, ovf: 1'b0}, 18, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
